// File: rtl/datapath_ctrl_fsm.sv
// Moore controller sequencing the RISC Machine datapath for MOV/ALU instructions.
// Handshakes with the CPU top through s (start) and w (idle/ready).
module datapath_ctrl_fsm #(
  parameter int unsigned ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       illegal
);

  typedef enum logic [2:0] {
    StWait   = 3'b000,
    StDecode = 3'b001,
    StGetA   = 3'b010,
    StGetB   = 3'b011,
    StAlu    = 3'b100,
    StWrRd   = 3'b101,
    StWrIm   = 3'b110,
    StHalt   = 3'b111
  } state_e;

  localparam logic [4:0] InstrMovImm = 5'b110_10;
  localparam logic [4:0] InstrMovReg = 5'b110_00;
  localparam logic [4:0] InstrAdd    = 5'b101_00;
  localparam logic [4:0] InstrCmp    = 5'b101_01;
  localparam logic [4:0] InstrAnd    = 5'b101_10;
  localparam logic [4:0] InstrMvn    = 5'b101_11;

  localparam logic [2:0] NselNone = 3'b000;
  localparam logic [2:0] NselRn   = 3'b001;
  localparam logic [2:0] NselRd   = 3'b010;
  localparam logic [2:0] NselRm   = 3'b100;

  localparam logic [1:0] VselC     = 2'b00;
  localparam logic [1:0] VselImm8  = 2'b10;

  state_e     present_state;
  state_e     next_state;
  logic [4:0] instr_q;

  // Instruction class flags, all derived from the captured instruction only.
  logic is_legal;
  logic is_mov_imm;
  logic needs_a;
  logic zero_a;
  logic is_cmp;

  always_comb begin
    is_legal   = 1'b1;
    is_mov_imm = 1'b0;
    needs_a    = 1'b0;
    zero_a     = 1'b0;
    is_cmp     = 1'b0;
    case (instr_q)
      InstrMovImm: is_mov_imm = 1'b1;
      InstrMovReg: zero_a     = 1'b1;
      InstrAdd:    needs_a    = 1'b1;
      InstrCmp: begin
        needs_a = 1'b1;
        is_cmp  = 1'b1;
      end
      InstrAnd:    needs_a    = 1'b1;
      InstrMvn:    zero_a     = 1'b1;
      default:     is_legal   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      present_state <= StWait;
      instr_q       <= 5'b0;
    end else begin
      present_state <= next_state;
      if (present_state == StWait && s) begin
        instr_q <= {opcode, op};
      end
    end
  end

  always_comb begin
    next_state = present_state;
    w          = 1'b0;
    nsel       = NselNone;
    vsel       = VselC;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    illegal    = 1'b0;

    unique case (present_state)
      StWait: begin
        w = 1'b1;
        if (s) begin
          next_state = StDecode;
        end
      end
      StDecode: begin
        if (!is_legal) begin
          illegal    = 1'b1;
          next_state = (ILLEGAL_TRAP != 0) ? StHalt : StWait;
        end else if (is_mov_imm) begin
          next_state = StWrIm;
        end else if (needs_a) begin
          next_state = StGetA;
        end else begin
          next_state = StGetB;
        end
      end
      StGetA: begin
        nsel       = NselRn;
        loada      = 1'b1;
        next_state = StGetB;
      end
      StGetB: begin
        nsel       = NselRm;
        loadb      = 1'b1;
        next_state = StAlu;
      end
      StAlu: begin
        loadc      = 1'b1;
        asel       = zero_a;
        loads      = is_cmp;
        // CMP only updates status; nothing to write back.
        next_state = is_cmp ? StWait : StWrRd;
      end
      StWrRd: begin
        nsel       = NselRd;
        vsel       = VselC;
        write      = 1'b1;
        next_state = StWait;
      end
      StWrIm: begin
        nsel       = NselRn;
        vsel       = VselImm8;
        write      = 1'b1;
        next_state = StWait;
      end
      StHalt: begin
        next_state = StHalt;
      end
    endcase
  end

endmodule
